// File: rtl/frame_fill_engine.sv
// Rectangle-fill and single-pixel plot engine for a 640x480 video RAM.
// Origin, size and colour are bus-programmed; fills issue one pixel per clock in raster order.
module frame_fill_engine #(
  parameter int DW   = 9,
  parameter int HRES = 640,
  parameter int VRES = 480
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cs,
  input  logic          write,
  input  logic          read,
  input  logic [4:0]    addr,
  input  logic [31:0]   wr_data,
  output logic [31:0]   rd_data,
  output logic [18:0]   addr_pix,
  output logic [DW-1:0] wr_data_pix,
  output logic          write_pix
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    FINISH = 2'd2
  } state_t;

  localparam logic [11:0] HRES_C   = 12'(HRES);
  localparam logic [11:0] VRES_C   = 12'(VRES);
  localparam logic [18:0] ROW_STEP = 19'(HRES);

  state_t        state_q, state_d;
  logic [10:0]   x0_q, x0_d, y0_q, y0_d, w_q, w_d, h_q, h_d;
  logic [DW-1:0] color_q, color_d;
  logic [11:0]   px_q, px_d, py_q, py_d;
  logic [10:0]   col_q, col_d, row_q, row_d;
  logic [18:0]   base_q, base_d;
  logic          last_q, last_d;
  logic          done_q, done_d;
  logic          write_pix_q, write_pix_d;
  logic [18:0]   addr_pix_q, addr_pix_d;
  logic [DW-1:0] wr_data_pix_q, wr_data_pix_d;

  logic          bus_wr, busy, start, plot, do_issue;
  logic [18:0]   y0_ext, base0;
  logic [11:0]   iss_x, iss_y;
  logic [18:0]   iss_base, iss_addr;
  logic [10:0]   iss_col, iss_row;
  logic          iss_on, iss_end_row, iss_last;

  // Bus transfers have no backpressure: a write is taken in any cycle with cs & write high,
  // and read data is a pure decode of addr with no strobe timing.
  logic unused_ok;
  assign unused_ok = &{1'b0, read, wr_data[31:11]};

  always_comb begin
    bus_wr = cs & write;
    busy   = (state_q != IDLE);
    start  = bus_wr && !busy && (addr == 5'd5);
    plot   = bus_wr && !busy && (addr == 5'd6);
    y0_ext = 19'(y0_q);
    base0  = (y0_ext << 9) + (y0_ext << 7);

    // The start cycle issues the origin pixel itself, so the first write lands one cycle later.
    if (state_q == FILL) begin
      iss_x    = px_q;
      iss_y    = py_q;
      iss_base = base_q;
      iss_col  = col_q;
      iss_row  = row_q;
    end else begin
      iss_x    = {1'b0, x0_q};
      iss_y    = {1'b0, y0_q};
      iss_base = base0;
      iss_col  = 11'd0;
      iss_row  = 11'd0;
    end
    iss_on      = (iss_x < HRES_C) && (iss_y < VRES_C);
    iss_addr    = iss_base + 19'(iss_x);
    iss_end_row = (iss_col == w_q - 11'd1);
    iss_last    = iss_end_row && (iss_row == h_q - 11'd1);

    state_d       = state_q;
    x0_d          = x0_q;
    y0_d          = y0_q;
    w_d           = w_q;
    h_d           = h_q;
    color_d       = color_q;
    px_d          = px_q;
    py_d          = py_q;
    col_d         = col_q;
    row_d         = row_q;
    base_d        = base_q;
    last_d        = last_q;
    done_d        = done_q;
    write_pix_d   = 1'b0;
    addr_pix_d    = addr_pix_q;
    wr_data_pix_d = wr_data_pix_q;
    do_issue      = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus_wr) begin
          case (addr)
            5'd0: x0_d = wr_data[10:0];
            5'd1: y0_d = wr_data[10:0];
            5'd2: w_d = wr_data[10:0];
            5'd3: h_d = wr_data[10:0];
            5'd4: color_d = wr_data[DW-1:0];
            default: ;
          endcase
        end
        if (start) begin
          done_d = 1'b0;
          if (w_q != 11'd0 && h_q != 11'd0) begin
            state_d  = FILL;
            do_issue = 1'b1;
          end else begin
            state_d = FINISH;
          end
        end
        if (plot) begin
          write_pix_d   = iss_on;
          addr_pix_d    = iss_addr;
          wr_data_pix_d = wr_data[DW-1:0];
        end
      end
      FILL: begin
        if (last_q) state_d = FINISH;
        else        do_issue = 1'b1;
      end
      FINISH: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // Clipped pixels still advance the walk so a fill always takes W*H cycles.
    if (do_issue) begin
      write_pix_d   = iss_on;
      addr_pix_d    = iss_addr;
      wr_data_pix_d = color_q;
      last_d        = iss_last;
      if (iss_end_row) begin
        px_d   = {1'b0, x0_q};
        py_d   = iss_y + 12'd1;
        base_d = iss_base + ROW_STEP;
        col_d  = 11'd0;
        row_d  = iss_row + 11'd1;
      end else begin
        px_d   = iss_x + 12'd1;
        py_d   = iss_y;
        base_d = iss_base;
        col_d  = iss_col + 11'd1;
        row_d  = iss_row;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      x0_q          <= '0;
      y0_q          <= '0;
      w_q           <= '0;
      h_q           <= '0;
      color_q       <= '0;
      px_q          <= '0;
      py_q          <= '0;
      col_q         <= '0;
      row_q         <= '0;
      base_q        <= '0;
      last_q        <= 1'b0;
      done_q        <= 1'b0;
      write_pix_q   <= 1'b0;
      addr_pix_q    <= '0;
      wr_data_pix_q <= '0;
    end else begin
      state_q       <= state_d;
      x0_q          <= x0_d;
      y0_q          <= y0_d;
      w_q           <= w_d;
      h_q           <= h_d;
      color_q       <= color_d;
      px_q          <= px_d;
      py_q          <= py_d;
      col_q         <= col_d;
      row_q         <= row_d;
      base_q        <= base_d;
      last_q        <= last_d;
      done_q        <= done_d;
      write_pix_q   <= write_pix_d;
      addr_pix_q    <= addr_pix_d;
      wr_data_pix_q <= wr_data_pix_d;
    end
  end

  always_comb begin
    rd_data = 32'd0;
    if (addr == 5'd7) rd_data = {30'd0, done_q, busy};
  end

  assign write_pix   = write_pix_q;
  assign addr_pix    = addr_pix_q;
  assign wr_data_pix = wr_data_pix_q;

endmodule

// File: tb/tb_frame_fill_engine.sv
// Directed bench for frame_fill_engine: a monitor captures every pixel write,
// a raster model fills the expected queue, and each step checks against it.
module tb_frame_fill_engine;

  localparam int DW = 9;

  logic          clk = 1'b0;
  logic          reset;
  logic          cs, write, read;
  logic [4:0]    addr;
  logic [31:0]   wr_data;
  logic [31:0]   rd_data;
  logic [18:0]   addr_pix;
  logic [DW-1:0] wr_data_pix;
  logic          write_pix;

  int n_assert = 0;
  int n_fail = 0;
  int cyc = 0;
  int busy_cnt = 0;
  int start_cyc = 0;
  int fill_start = 0;

  logic [18:0]   exp_q[$];
  int            exp_off_q[$];
  logic [18:0]   got_addr[$];
  logic [DW-1:0] got_data[$];
  int            got_cyc[$];

  frame_fill_engine #(.DW(DW), .HRES(640), .VRES(480)) dut (
    .clk         (clk),
    .reset       (reset),
    .cs          (cs),
    .write       (write),
    .read        (read),
    .addr        (addr),
    .wr_data     (wr_data),
    .rd_data     (rd_data),
    .addr_pix    (addr_pix),
    .wr_data_pix (wr_data_pix),
    .write_pix   (write_pix)
  );

  // clock / monitor
  always #5 clk = ~clk;

  always begin
    @(posedge clk);
    cyc++;
    #2;
    if (write_pix === 1'b1) begin
      got_addr.push_back(addr_pix);
      got_data.push_back(wr_data_pix);
      got_cyc.push_back(cyc);
    end
    if (addr == 5'd7 && rd_data[0] === 1'b1) busy_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // driver tasks: called at a negedge, return at the negedge after the capturing edge
  task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
    cs = 1'b1; write = 1'b1; addr = a; wr_data = d;
    start_cyc = cyc + 1;
    @(posedge clk);
    #1;
    cs = 1'b0; write = 1'b0; addr = 5'd7; wr_data = 32'd0;
    @(negedge clk);
  endtask

  task automatic set_rect(input int x0, input int y0, input int w, input int h, input int color);
    bus_write(5'd0, x0);
    bus_write(5'd1, y0);
    bus_write(5'd2, w);
    bus_write(5'd3, h);
    bus_write(5'd4, color);
  endtask

  task automatic clear_capture();
    got_addr.delete();
    got_data.delete();
    got_cyc.delete();
    busy_cnt = 0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (rd_data[0] === 1'b1 && n < 30000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_timeout"}, (n < 30000), 1);
  endtask

  // scoreboard model: raster walk with clipping, 640*y+x addressing
  task automatic build_exp(input int x0, input int y0, input int w, input int h);
    exp_q.delete();
    exp_off_q.delete();
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        if ((x0 + c) < 640 && (y0 + r) < 480) begin
          exp_q.push_back(19'(640 * (y0 + r) + (x0 + c)));
          exp_off_q.push_back(r * w + c);
        end
      end
    end
  endtask

  task automatic check_writes(input string tag, input int s_cyc, input int color);
    int n;
    n = exp_q.size();
    chk({tag, "_count"}, got_addr.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < got_addr.size()) begin
        chk($sformatf("%s_addr%0d", tag, i), got_addr[i], exp_q[i]);
        chk($sformatf("%s_data%0d", tag, i), got_data[i], color);
        chk($sformatf("%s_cyc%0d", tag, i), got_cyc[i] - s_cyc, exp_off_q[i]);
      end
    end
  endtask

  initial begin
    reset = 1'b1; cs = 1'b0; write = 1'b0; read = 1'b1; addr = 5'd7; wr_data = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_write_pix", write_pix, 0);
    chk("rst_addr_pix", addr_pix, 0);
    chk("rst_wr_data_pix", wr_data_pix, 0);
    chk("rst_status", rd_data, 0);
    reset = 1'b0;
    @(negedge clk);
    addr = 5'd0;
    #1;
    chk("rd_addr0_zero", rd_data, 0);
    addr = 5'd7;

    // 3x2 fill fully on-screen
    set_rect(10, 2, 3, 2, 'h1A5);
    clear_capture();
    bus_write(5'd5, 32'hFFFF_FFFF);
    wait_idle("fill3x2");
    build_exp(10, 2, 3, 2);
    chk("fill3x2_first_addr", (exp_q.size() > 0) ? exp_q[0] : 19'd0, 1290);
    check_writes("fill3x2", start_cyc, 'h1A5);
    chk("fill3x2_busy", busy_cnt, 7);
    chk("fill3x2_status", rd_data, 2);

    // bottom-right corner, mostly clipped
    set_rect(638, 479, 4, 3, 'h0AA);
    clear_capture();
    bus_write(5'd5, 0);
    wait_idle("corner");
    build_exp(638, 479, 4, 3);
    chk("corner_last_addr", got_addr.size() == 2 ? got_addr[1] : 19'd0, 307199);
    check_writes("corner", start_cyc, 'h0AA);
    chk("corner_busy", busy_cnt, 13);

    // coordinates past 2047 stay clipped instead of wrapping
    set_rect(2046, 0, 4, 1, 'h011);
    clear_capture();
    bus_write(5'd5, 0);
    wait_idle("wrap");
    chk("wrap_count", got_addr.size(), 0);
    chk("wrap_busy", busy_cnt, 5);

    // zero-width start
    set_rect(0, 0, 0, 5, 'h022);
    clear_capture();
    bus_write(5'd5, 0);
    chk("zero_status_c1", rd_data, 1);
    @(negedge clk);
    chk("zero_status_c2", rd_data, 2);
    chk("zero_count", got_addr.size(), 0);
    chk("zero_busy", busy_cnt, 1);

    // single pixel at right edge of row 0
    bus_write(5'd0, 639);
    bus_write(5'd1, 0);
    clear_capture();
    bus_write(5'd6, 'h0FF);
    repeat (2) @(negedge clk);
    chk("plot_count", got_addr.size(), 1);
    chk("plot_addr", got_addr.size() > 0 ? got_addr[0] : 19'd0, 639);
    chk("plot_data", got_data.size() > 0 ? got_data[0] : 9'd0, 'h0FF);
    chk("plot_cyc", got_cyc.size() > 0 ? got_cyc[0] - start_cyc : -1, 0);
    chk("plot_busy", busy_cnt, 0);

    // 100x100 fill with a register write and restart attempted while busy
    set_rect(5, 7, 100, 100, 'h055);
    clear_capture();
    bus_write(5'd5, 0);
    fill_start = start_cyc;
    repeat (3) @(negedge clk);
    bus_write(5'd0, 0);
    bus_write(5'd5, 0);
    wait_idle("big");
    build_exp(5, 7, 100, 100);
    check_writes("big", fill_start, 'h055);
    clear_capture();
    bus_write(5'd6, 'h033);
    repeat (2) @(negedge clk);
    chk("big_x0_held", got_addr.size() > 0 ? got_addr[0] : 19'd0, 4485);

    // reset in the middle of a fill
    set_rect(0, 0, 100, 100, 'h1FF);
    clear_capture();
    bus_write(5'd5, 0);
    repeat (19) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midrst_write_pix", write_pix, 0);
    chk("midrst_count", got_addr.size(), 20);
    chk("midrst_status", rd_data, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    chk("postrst_count", got_addr.size(), 20);
    chk("postrst_status", rd_data, 0);

    // first start after reset
    set_rect(3, 1, 2, 2, 'h123);
    clear_capture();
    bus_write(5'd5, 0);
    wait_idle("after_rst");
    build_exp(3, 1, 2, 2);
    check_writes("after_rst", start_cyc, 'h123);
    chk("after_rst_busy", busy_cnt, 5);
    chk("after_rst_status", rd_data, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
